// File: rtl/rst_seq.sv
// rst_seq: staged reset sequencer clocked by the buffered global clock.
// Waits for clock-source lock, holds for a stable interval, then releases
// active-high reset outputs one stage at a time (bit 0 first).
//
// Ports:
//   clk             buffered global clock
//   rst             asynchronous active-high reset (button / POR)
//   locked_i        clock-source lock, asynchronous to clk
//   soft_rst_req_i  synchronous soft-reset request (honoured only in RUN)
//   rst_out_o       staged active-high resets, bit 0 releases first
//   ready_o         high once every stage is released
//   lock_loss_cnt_o saturating 8-bit lock-loss event count
//                   (present only when RST_SEQ_LOCK_LOSS_CNT_EN is defined)
//
// Optional feature macro: RST_SEQ_LOCK_LOSS_CNT_EN
module rst_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned STAGE_GAP   = 16,
  parameter int unsigned NUM_STAGES  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked_i,
  input  logic                  soft_rst_req_i,
  output logic [NUM_STAGES-1:0] rst_out_o,
  output logic                  ready_o
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0]            lock_loss_cnt_o
`endif
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int unsigned IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    locked_s;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]        stage_idx_q, stage_idx_d;
  logic [NUM_STAGES-1:0]   rst_out_q, rst_out_d;
  logic                    ready_q, ready_d;
  logic                    lock_loss;

  // Lock synchroniser: shift locked_i through SYNC_STAGES flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_i};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      stage_idx_q <= '0;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      stage_idx_q <= stage_idx_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state and next-output logic; lock loss overrides everything but WAIT_LOCK
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    stage_idx_d = stage_idx_q;
    rst_out_d   = rst_out_q;
    ready_d     = ready_q;
    lock_loss   = 1'b0;

    unique case (state_q)
      WAIT_LOCK: begin
        rst_out_d   = '1;
        ready_d     = 1'b0;
        hold_cnt_d  = '0;
        gap_cnt_d   = '0;
        stage_idx_d = '0;
        if (locked_s) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (!locked_s) begin
          lock_loss = 1'b1;
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          hold_cnt_d = '0;
          if (NUM_STAGES == 1) begin
            // Single stage: release and ready on the same edge
            rst_out_d = '0;
            ready_d   = 1'b1;
            state_d   = RUN;
          end else begin
            rst_out_d   = rst_out_q & ~NUM_STAGES'(1);
            gap_cnt_d   = '0;
            stage_idx_d = IDX_W'(1);
            state_d     = RELEASE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      RELEASE: begin
        if (!locked_s) begin
          lock_loss = 1'b1;
        end else if (gap_cnt_q == GAP_W'(STAGE_GAP - 1)) begin
          rst_out_d   = rst_out_q & ~(NUM_STAGES'(1) << stage_idx_q);
          gap_cnt_d   = '0;
          stage_idx_d = stage_idx_q + IDX_W'(1);
          if (stage_idx_q == IDX_W'(NUM_STAGES - 1)) begin
            ready_d = 1'b1;
            state_d = RUN;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      RUN: begin
        if (!locked_s) begin
          lock_loss = 1'b1;
        end else if (soft_rst_req_i) begin
          // Soft reset skips the lock wait and restarts the hold interval
          rst_out_d   = '1;
          ready_d     = 1'b0;
          hold_cnt_d  = '0;
          gap_cnt_d   = '0;
          stage_idx_d = '0;
          state_d     = HOLD;
        end
      end

      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    if (lock_loss) begin
      rst_out_d   = '1;
      ready_d     = 1'b0;
      hold_cnt_d  = '0;
      gap_cnt_d   = '0;
      stage_idx_d = '0;
      state_d     = WAIT_LOCK;
    end
  end

  assign rst_out_o = rst_out_q;
  assign ready_o   = ready_q;

`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt_q;

  // Saturating lock-loss event counter, cleared only by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_loss_cnt_q <= '0;
    end else if (lock_loss && (lock_loss_cnt_q != 8'hFF)) begin
      lock_loss_cnt_q <= lock_loss_cnt_q + 8'd1;
    end
  end

  assign lock_loss_cnt_o = lock_loss_cnt_q;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed bench for rst_seq with SYNC_STAGES=2, HOLD_CYCLES=8,
// STAGE_GAP=4. Instance dut has NUM_STAGES=3, dut1 has NUM_STAGES=1; both
// share stimulus. Release edges counted from the first edge after the
// lock is presented: 11, 15, 19 for dut and 11 for dut1.
module tb_rst_seq;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned HOLD_CYCLES = 8;
  localparam int unsigned STAGE_GAP   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked_i = 1'b0;
  logic       soft_rst_req_i = 1'b0;
  logic [2:0] rst_out;
  logic       ready;
  logic [0:0] rst_out1;
  logic       ready1;
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
  logic [7:0] llc;
  logic [7:0] llc1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rst_seq #(
    .SYNC_STAGES(SYNC_STAGES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .STAGE_GAP  (STAGE_GAP),
    .NUM_STAGES (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .locked_i       (locked_i),
    .soft_rst_req_i (soft_rst_req_i),
    .rst_out_o      (rst_out),
    .ready_o        (ready)
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
    ,
    .lock_loss_cnt_o(llc)
`endif
  );

  rst_seq #(
    .SYNC_STAGES(SYNC_STAGES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .STAGE_GAP  (STAGE_GAP),
    .NUM_STAGES (1)
  ) dut1 (
    .clk            (clk),
    .rst            (rst),
    .locked_i       (locked_i),
    .soft_rst_req_i (soft_rst_req_i),
    .rst_out_o      (rst_out1),
    .ready_o        (ready1)
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
    ,
    .lock_loss_cnt_o(llc1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_out, input logic e_rdy,
                         input logic e_out1, input logic e_rdy1);
    chk({tag, " rst_out"},  8'(rst_out),  e_out);
    chk({tag, " ready"},    8'(ready),    8'(e_rdy));
    chk({tag, " rst_out1"}, 8'(rst_out1), 8'(e_out1));
    chk({tag, " ready1"},   8'(ready1),   8'(e_rdy1));
  endtask

  // Edges 1..last_e after lock is presented from a cleared synchroniser
  task automatic run_seq(input string tag, input int last_e);
    for (int e = 1; e <= last_e; e++) begin
      tick();
      chk_all($sformatf("%s e%0d", tag, e),
              (e < 11) ? 8'h07 : (e < 15) ? 8'h06 : (e < 19) ? 8'h04 : 8'h00,
              (e >= 19), (e < 11), (e >= 11));
    end
  endtask

`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
  // One lock-loss event: lock long enough to leave WAIT_LOCK, then drop it
  task automatic loss_events(input int n);
    for (int i = 0; i < n; i++) begin
      locked_i = 1'b1;
      repeat (3) tick();
      locked_i = 1'b0;
      repeat (3) tick();
    end
  endtask
`endif

  initial begin
    // Reset state
    tick();
    tick();
    chk_all("reset", 8'h07, 1'b0, 1'b1, 1'b0);

    // Power-up
    rst      = 1'b0;
    locked_i = 1'b1;
    run_seq("pwrup", 19);

    // Soft reset in RUN: re-assert next edge, first release 8 edges later
    soft_rst_req_i = 1'b1;
    tick();
    soft_rst_req_i = 1'b0;
    chk("soft run rst_out", 8'(rst_out), 8'h07);
    chk("soft run ready", 8'(ready), 8'h00);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("soft hold %0d", i), 8'(rst_out), (i < 8) ? 8'h07 : 8'h06);
    end
    // Same pulse in RELEASE is ignored
    soft_rst_req_i = 1'b1;
    tick();
    soft_rst_req_i = 1'b0;
    chk("soft rel rst_out", 8'(rst_out), 8'h06);
    for (int i = 10; i <= 16; i++) begin
      tick();
      chk($sformatf("soft rel %0d rst_out", i), 8'(rst_out),
          (i < 12) ? 8'h06 : (i < 16) ? 8'h04 : 8'h00);
      chk($sformatf("soft rel %0d ready", i), 8'(ready), 8'(i >= 16));
    end

    // Lock loss in RUN: takes effect SYNC_STAGES+1 edges after the drop
    locked_i = 1'b0;
    tick();
    chk("loss run e1", 8'(rst_out), 8'h00);
    tick();
    chk("loss run e2", 8'(rst_out), 8'h00);
    tick();
    chk_all("loss run e3", 8'h07, 1'b0, 1'b1, 1'b0);

    // Lock loss in HOLD: no release while lock is absent
    locked_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("hold pre %0d", i), 8'(rst_out), 8'h07);
    end
    locked_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_all($sformatf("hold loss %0d", i), 8'h07, 1'b0, 1'b1, 1'b0);
    end
    locked_i = 1'b1;
    run_seq("relock", 19);

    // Simultaneous soft request and lock loss: lock loss wins
    locked_i = 1'b0;
    tick();
    tick();
    chk_all("simul pre", 8'h00, 1'b1, 1'b0, 1'b1);
    soft_rst_req_i = 1'b1;
    tick();
    soft_rst_req_i = 1'b0;
    chk_all("simul edge", 8'h07, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("simul wait %0d", i), 8'(rst_out), 8'h07);
    end

    // Async reset mid-RELEASE
    locked_i = 1'b1;
    run_seq("pre async", 12);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async", 8'h07, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    run_seq("post async", 19);

`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
    chk("llc after rst", llc, 8'd0);
    chk("llc1 after rst", llc1, 8'd0);
    loss_events(10);
    chk("llc 10", llc, 8'd10);
    chk("llc1 10", llc1, 8'd10);
    locked_i = 1'b1;
    run_seq("cnt relock", 19);
    soft_rst_req_i = 1'b1;
    tick();
    soft_rst_req_i = 1'b0;
    chk("cnt soft rst_out", 8'(rst_out), 8'h07);
    chk("llc soft", llc, 8'd10);
    chk("llc1 soft", llc1, 8'd10);
    loss_events(290);
    chk("llc sat", llc, 8'd255);
    chk("llc1 sat", llc1, 8'd255);
    #2;
    rst = 1'b1;
    #1;
    chk("llc rst", llc, 8'd0);
    chk("llc1 rst", llc1, 8'd0);
    tick();
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
